// File: rtl/alu_sequencer_if.sv
// Operation-request and result handshake bundle for alu_sequencer.
// master drives requests and accepts results; slave is the sequencer side.
interface alu_sequencer_if;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] op_code;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;

    modport master (
        output op_valid, op_code, a_in, b_in, res_ready,
        input  op_ready, res_valid, res_data
    );

    modport slave (
        input  op_valid, op_code, a_in, b_in, res_ready,
        output op_ready, res_valid, res_data
    );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences 6502-style ALU operations onto an external combinational ALU.
// Optional rotate ops (ASL/ROL/ROR) are enabled by defining ALU_SEQ_ROTATE_EN.
module alu_sequencer (
    input  logic              clk,
    input  logic              rst,
    alu_sequencer_if.slave    seq,
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_v,
    output logic              alu_add_en,
    output logic              alu_and_en,
    output logic              alu_xor_en,
    output logic              alu_or_en,
    output logic              alu_sr_en,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic              alu_carry_in,
    input  logic [7:0]        alu_c_out,
    input  logic              alu_carry_out,
    input  logic              alu_ovflw
);

    localparam logic [3:0] OP_ADC = 4'd0;
    localparam logic [3:0] OP_SBC = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_ORA = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_LSR = 4'd6;
`ifdef ALU_SEQ_ROTATE_EN
    localparam logic [3:0] OP_ASL = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8;
    localparam logic [3:0] OP_ROR = 4'd9;
`endif
    localparam logic [3:0] OP_CLC = 4'd10;
    localparam logic [3:0] OP_SEC = 4'd11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        EXEC2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state_r;
    logic [3:0] op_r;
    logic [7:0] a_r;
    logic       carry_tmp_r;

    logic       dec_add_s;
    logic       dec_and_s;
    logic       dec_xor_s;
    logic       dec_or_s;
    logic       dec_sr_s;
    logic [7:0] dec_a_s;
    logic [7:0] dec_b_s;
    logic       dec_cin_s;

    function automatic logic is_zero(input logic [7:0] v);
        return (v == 8'h00);
    endfunction

    // Decode the ALU drive for the op being offered; registered on handshake.
    always_comb begin
        dec_add_s = 1'b0;
        dec_and_s = 1'b0;
        dec_xor_s = 1'b0;
        dec_or_s  = 1'b0;
        dec_sr_s  = 1'b0;
        dec_a_s   = 8'h00;
        dec_b_s   = 8'h00;
        dec_cin_s = 1'b0;
        case (seq.op_code)
            OP_ADC: begin dec_add_s = 1'b1; dec_a_s = seq.a_in; dec_b_s = seq.b_in;  dec_cin_s = flag_c; end
            OP_SBC: begin dec_add_s = 1'b1; dec_a_s = seq.a_in; dec_b_s = ~seq.b_in; dec_cin_s = flag_c; end
            OP_AND: begin dec_and_s = 1'b1; dec_a_s = seq.a_in; dec_b_s = seq.b_in; end
            OP_ORA: begin dec_or_s  = 1'b1; dec_a_s = seq.a_in; dec_b_s = seq.b_in; end
            OP_EOR: begin dec_xor_s = 1'b1; dec_a_s = seq.a_in; dec_b_s = seq.b_in; end
            OP_CMP: begin dec_add_s = 1'b1; dec_a_s = seq.a_in; dec_b_s = ~seq.b_in; dec_cin_s = 1'b1; end
            OP_LSR: begin dec_sr_s  = 1'b1; dec_a_s = seq.a_in; end
`ifdef ALU_SEQ_ROTATE_EN
            OP_ASL: begin dec_add_s = 1'b1; dec_a_s = seq.a_in; dec_b_s = seq.a_in; dec_cin_s = 1'b0; end
            OP_ROL: begin dec_add_s = 1'b1; dec_a_s = seq.a_in; dec_b_s = seq.a_in; dec_cin_s = flag_c; end
            OP_ROR: begin dec_sr_s  = 1'b1; dec_a_s = seq.a_in; end
`endif
            default: dec_add_s = 1'b0;
        endcase
    end

    // Sequencer FSM with registered handshake, flag and ALU-drive outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            op_r          <= 4'd0;
            a_r           <= 8'h00;
            carry_tmp_r   <= 1'b0;
            seq.op_ready  <= 1'b1;
            seq.res_valid <= 1'b0;
            seq.res_data  <= 8'h00;
            flag_n        <= 1'b0;
            flag_z        <= 1'b0;
            flag_c        <= 1'b0;
            flag_v        <= 1'b0;
            alu_add_en    <= 1'b0;
            alu_and_en    <= 1'b0;
            alu_xor_en    <= 1'b0;
            alu_or_en     <= 1'b0;
            alu_sr_en     <= 1'b0;
            alu_a         <= 8'h00;
            alu_b         <= 8'h00;
            alu_carry_in  <= 1'b0;
        end else begin
            // ALU drive is live only for the cycle(s) it was loaded for.
            alu_add_en   <= 1'b0;
            alu_and_en   <= 1'b0;
            alu_xor_en   <= 1'b0;
            alu_or_en    <= 1'b0;
            alu_sr_en    <= 1'b0;
            alu_a        <= 8'h00;
            alu_b        <= 8'h00;
            alu_carry_in <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (seq.op_valid) begin
                        op_r         <= seq.op_code;
                        a_r          <= seq.a_in;
                        seq.op_ready <= 1'b0;
                        state_r      <= EXEC;
                        alu_add_en   <= dec_add_s;
                        alu_and_en   <= dec_and_s;
                        alu_xor_en   <= dec_xor_s;
                        alu_or_en    <= dec_or_s;
                        alu_sr_en    <= dec_sr_s;
                        alu_a        <= dec_a_s;
                        alu_b        <= dec_b_s;
                        alu_carry_in <= dec_cin_s;
                    end
                end
                EXEC: begin
                    state_r       <= DONE;
                    seq.res_valid <= 1'b1;
                    case (op_r)
                        OP_ADC, OP_SBC: begin
                            seq.res_data <= alu_c_out;
                            flag_c       <= alu_carry_out;
                            flag_v       <= alu_ovflw;
                            flag_n       <= alu_c_out[7];
                            flag_z       <= is_zero(alu_c_out);
                        end
                        OP_AND, OP_ORA, OP_EOR: begin
                            seq.res_data <= alu_c_out;
                            flag_n       <= alu_c_out[7];
                            flag_z       <= is_zero(alu_c_out);
                        end
                        OP_CMP: begin
                            seq.res_data <= a_r;
                            flag_c       <= alu_carry_out;
                            flag_n       <= alu_c_out[7];
                            flag_z       <= is_zero(alu_c_out);
                        end
                        OP_LSR: begin
                            seq.res_data <= alu_c_out;
                            flag_c       <= alu_carry_out;
                            flag_n       <= 1'b0;
                            flag_z       <= is_zero(alu_c_out);
                        end
`ifdef ALU_SEQ_ROTATE_EN
                        OP_ASL, OP_ROL: begin
                            seq.res_data <= alu_c_out;
                            flag_c       <= alu_carry_out;
                            flag_n       <= alu_c_out[7];
                            flag_z       <= is_zero(alu_c_out);
                        end
                        // Second pass ORs the pre-op carry into bit 7; flags wait for it.
                        OP_ROR: begin
                            state_r       <= EXEC2;
                            seq.res_valid <= 1'b0;
                            carry_tmp_r   <= alu_carry_out;
                            alu_or_en     <= 1'b1;
                            alu_a         <= alu_c_out;
                            alu_b         <= {flag_c, 7'b0000000};
                        end
`endif
                        OP_CLC: begin
                            seq.res_data <= a_r;
                            flag_c       <= 1'b0;
                        end
                        OP_SEC: begin
                            seq.res_data <= a_r;
                            flag_c       <= 1'b1;
                        end
                        default: seq.res_data <= a_r;
                    endcase
                end
                EXEC2: begin
                    state_r       <= DONE;
                    seq.res_valid <= 1'b1;
                    seq.res_data  <= alu_c_out;
                    flag_c        <= carry_tmp_r;
                    flag_n        <= alu_c_out[7];
                    flag_z        <= is_zero(alu_c_out);
                end
                DONE: begin
                    if (seq.res_ready) begin
                        seq.res_valid <= 1'b0;
                        seq.op_ready  <= 1'b1;
                        state_r       <= IDLE;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    seq.op_ready  <= 1'b1;
                    seq.res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural ALU model.
// Expectations follow the ALU_SEQ_ROTATE_EN setting of the build.
module tb_alu_sequencer;

    logic       clk;
    logic       rst;
    logic       flag_n, flag_z, flag_c, flag_v;
    logic       alu_add_en, alu_and_en, alu_xor_en, alu_or_en, alu_sr_en;
    logic [7:0] alu_a, alu_b;
    logic       alu_carry_in;
    logic [7:0] alu_c_out;
    logic       alu_carry_out;
    logic       alu_ovflw;
    logic [8:0] sum_s;

    int checks   = 0;
    int failures = 0;

    alu_sequencer_if seq_if ();

    alu_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .seq           (seq_if),
        .flag_n        (flag_n),
        .flag_z        (flag_z),
        .flag_c        (flag_c),
        .flag_v        (flag_v),
        .alu_add_en    (alu_add_en),
        .alu_and_en    (alu_and_en),
        .alu_xor_en    (alu_xor_en),
        .alu_or_en     (alu_or_en),
        .alu_sr_en     (alu_sr_en),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_carry_in  (alu_carry_in),
        .alu_c_out     (alu_c_out),
        .alu_carry_out (alu_carry_out),
        .alu_ovflw     (alu_ovflw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the external combinational ALU.
    always_comb begin
        sum_s         = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carry_in};
        alu_c_out     = 8'h00;
        alu_carry_out = 1'b0;
        alu_ovflw     = 1'b0;
        if (alu_add_en) begin
            alu_c_out     = sum_s[7:0];
            alu_carry_out = sum_s[8];
            alu_ovflw     = (alu_a[7] == alu_b[7]) && (sum_s[7] != alu_a[7]);
        end else if (alu_and_en) begin
            alu_c_out = alu_a & alu_b;
        end else if (alu_xor_en) begin
            alu_c_out = alu_a ^ alu_b;
        end else if (alu_or_en) begin
            alu_c_out = alu_a | alu_b;
        end else if (alu_sr_en) begin
            alu_c_out     = {1'b0, alu_a[7:1]};
            alu_carry_out = alu_a[0];
        end else begin
            alu_c_out = 8'h00;
        end
    end

    function automatic logic [4:0] en_vec();
        return {alu_add_en, alu_and_en, alu_xor_en, alu_or_en, alu_sr_en};
    endfunction

    function automatic logic [3:0] flags();
        return {flag_n, flag_z, flag_c, flag_v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_alu_idle(input string tag);
        chk({tag, ":alu_idle"}, {9'd0, en_vec(), alu_a, alu_b, alu_carry_in}, 32'd0);
    endtask

    // Offer one op for a single cycle, then scramble the inputs.
    task automatic issue(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        seq_if.op_valid = 1'b1;
        seq_if.op_code  = c;
        seq_if.a_in     = a;
        seq_if.b_in     = b;
        tick();
        seq_if.op_valid = 1'b0;
        seq_if.op_code  = 4'hF;
        seq_if.a_in     = 8'hEE;
        seq_if.b_in     = 8'hEE;
    endtask

    task automatic release_result(input string tag);
        seq_if.res_ready = 1'b1;
        tick();
        seq_if.res_ready = 1'b0;
        chk({tag, ":res_valid_after"}, {31'd0, seq_if.res_valid}, 32'd0);
        chk({tag, ":op_ready_after"}, {31'd0, seq_if.op_ready}, 32'd1);
        chk_alu_idle(tag);
    endtask

    task automatic run_op(input string tag, input logic [3:0] c, input logic [7:0] a,
                          input logic [7:0] b, input logic [4:0] e_en, input logic [7:0] e_a,
                          input logic [7:0] e_b, input logic e_cin, input logic [7:0] e_res,
                          input logic [3:0] e_flags);
        chk({tag, ":op_ready"}, {31'd0, seq_if.op_ready}, 32'd1);
        issue(c, a, b);
        chk({tag, ":exec_en"}, {27'd0, en_vec()}, {27'd0, e_en});
        chk({tag, ":exec_ops"}, {15'd0, alu_a, alu_b, alu_carry_in}, {15'd0, e_a, e_b, e_cin});
        chk({tag, ":exec_res_valid"}, {31'd0, seq_if.res_valid}, 32'd0);
        tick();
        chk({tag, ":res_valid"}, {31'd0, seq_if.res_valid}, 32'd1);
        chk({tag, ":res_data"}, {24'd0, seq_if.res_data}, {24'd0, e_res});
        chk({tag, ":flags_nzcv"}, {28'd0, flags()}, {28'd0, e_flags});
        release_result(tag);
    endtask

    initial begin
        rst              = 1'b1;
        seq_if.op_valid  = 1'b0;
        seq_if.op_code   = 4'd0;
        seq_if.a_in      = 8'h00;
        seq_if.b_in      = 8'h00;
        seq_if.res_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset:op_ready", {31'd0, seq_if.op_ready}, 32'd1);
        chk("reset:res_valid", {31'd0, seq_if.res_valid}, 32'd0);
        chk("reset:res_data", {24'd0, seq_if.res_data}, 32'd0);
        chk("reset:flags", {28'd0, flags()}, 32'd0);
        chk_alu_idle("reset");

        run_op("adc", 4'd0, 8'h50, 8'h50, 5'b10000, 8'h50, 8'h50, 1'b0, 8'hA0, 4'b1001);
        run_op("cmp", 4'd5, 8'h40, 8'h40, 5'b10000, 8'h40, 8'hBF, 1'b1, 8'h40, 4'b0111);
        run_op("sbc", 4'd1, 8'h10, 8'h20, 5'b10000, 8'h10, 8'hDF, 1'b1, 8'hF0, 4'b1000);
        run_op("sec", 4'd11, 8'h12, 8'h34, 5'b00000, 8'h00, 8'h00, 1'b0, 8'h12, 4'b1010);
        run_op("and", 4'd2, 8'hF0, 8'h0F, 5'b01000, 8'hF0, 8'h0F, 1'b0, 8'h00, 4'b0110);
        run_op("eor", 4'd4, 8'hFF, 8'h0F, 5'b00100, 8'hFF, 8'h0F, 1'b0, 8'hF0, 4'b1010);
        run_op("ora", 4'd3, 8'h01, 8'h80, 5'b00010, 8'h01, 8'h80, 1'b0, 8'h81, 4'b1010);
        run_op("lsr", 4'd6, 8'h03, 8'h55, 5'b00001, 8'h03, 8'h00, 1'b0, 8'h01, 4'b0010);
        run_op("illegal", 4'd12, 8'h77, 8'h11, 5'b00000, 8'h00, 8'h00, 1'b0, 8'h77, 4'b0010);
        run_op("clc", 4'd10, 8'h55, 8'h00, 5'b00000, 8'h00, 8'h00, 1'b0, 8'h55, 4'b0000);
`ifdef ALU_SEQ_ROTATE_EN
        run_op("asl", 4'd7, 8'h81, 8'h00, 5'b10000, 8'h81, 8'h81, 1'b0, 8'h02, 4'b0010);
        run_op("rol", 4'd8, 8'h40, 8'h00, 5'b10000, 8'h40, 8'h40, 1'b1, 8'h81, 4'b1000);
        run_op("sec2", 4'd11, 8'h00, 8'h00, 5'b00000, 8'h00, 8'h00, 1'b0, 8'h00, 4'b1010);
        chk("ror:op_ready", {31'd0, seq_if.op_ready}, 32'd1);
        issue(4'd9, 8'h01, 8'h00);
        chk("ror:exec_en", {27'd0, en_vec()}, {27'd0, 5'b00001});
        chk("ror:exec_a", {24'd0, alu_a}, 32'h01);
        tick();
        chk("ror:exec2_res_valid", {31'd0, seq_if.res_valid}, 32'd0);
        chk("ror:exec2_en", {27'd0, en_vec()}, {27'd0, 5'b00010});
        chk("ror:exec2_ops", {16'd0, alu_a, alu_b}, {16'd0, 8'h00, 8'h80});
        chk("ror:exec2_flags_held", {28'd0, flags()}, {28'd0, 4'b1010});
        tick();
        chk("ror:res_valid", {31'd0, seq_if.res_valid}, 32'd1);
        chk("ror:res_data", {24'd0, seq_if.res_data}, 32'h80);
        chk("ror:flags_nzcv", {28'd0, flags()}, {28'd0, 4'b1010});
        release_result("ror");
`else
        run_op("asl", 4'd7, 8'h81, 8'h00, 5'b00000, 8'h00, 8'h00, 1'b0, 8'h81, 4'b0000);
        run_op("rol", 4'd8, 8'h40, 8'h00, 5'b00000, 8'h00, 8'h00, 1'b0, 8'h40, 4'b0000);
        run_op("sec2", 4'd11, 8'h00, 8'h00, 5'b00000, 8'h00, 8'h00, 1'b0, 8'h00, 4'b0010);
        run_op("ror", 4'd9, 8'h01, 8'h00, 5'b00000, 8'h00, 8'h00, 1'b0, 8'h01, 4'b0010);
`endif

        // ADC with carry in, then stall the result for five cycles.
        chk("adc_c:op_ready", {31'd0, seq_if.op_ready}, 32'd1);
        issue(4'd0, 8'h01, 8'h01);
        chk("adc_c:cin", {31'd0, alu_carry_in}, 32'd1);
        tick();
        seq_if.op_valid = 1'b1;
        seq_if.op_code  = 4'd11;
        seq_if.a_in     = 8'h99;
        for (int i = 0; i < 5; i++) begin
            chk("stall:res_valid", {31'd0, seq_if.res_valid}, 32'd1);
            chk("stall:res_data", {24'd0, seq_if.res_data}, 32'h03);
            chk("stall:op_ready", {31'd0, seq_if.op_ready}, 32'd0);
            chk("stall:flags", {28'd0, flags()}, 32'd0);
            tick();
        end
        seq_if.op_valid = 1'b0;
        release_result("stall");
        chk("stall:flags_after", {28'd0, flags()}, 32'd0);
        chk("stall:res_data_after", {24'd0, seq_if.res_data}, 32'h03);

        run_op("sec3", 4'd11, 8'h00, 8'h00, 5'b00000, 8'h00, 8'h00, 1'b0, 8'h00, 4'b0010);
        issue(4'd9, 8'h01, 8'h00);
        tick();
`ifdef ALU_SEQ_ROTATE_EN
        chk("rst_mid:in_exec2", {27'd0, en_vec()}, {27'd0, 5'b00010});
`else
        chk("rst_mid:in_done", {31'd0, seq_if.res_valid}, 32'd1);
`endif
        rst              = 1'b1;
        seq_if.op_valid  = 1'b1;
        seq_if.op_code   = 4'd11;
        seq_if.res_ready = 1'b1;
        tick();
        tick();
        rst              = 1'b0;
        seq_if.op_valid  = 1'b0;
        seq_if.res_ready = 1'b0;
        chk("rst_mid:op_ready", {31'd0, seq_if.op_ready}, 32'd1);
        chk("rst_mid:res_valid", {31'd0, seq_if.res_valid}, 32'd0);
        chk("rst_mid:res_data", {24'd0, seq_if.res_data}, 32'd0);
        chk("rst_mid:flags", {28'd0, flags()}, 32'd0);
        chk_alu_idle("rst_mid");
        tick();
        chk("rst_mid:still_idle", {31'd0, seq_if.op_ready}, 32'd1);
        chk_alu_idle("rst_mid2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
